fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Single-clock FIFO pointer and flag controller that sequences a synchronous dual-port RAM. It arbitrates write and read requests, maintains binary and Gray-coded pointers, and derives full, empty, almost-full, almost-empty and level from them. It registers a read-data-valid strobe aligned to the RAM's one-cycle read latency. It sits between user write/read ports and the FIFO RAM, and exports Gray pointers for later dual-clock reuse.

## Interface
- ADDRWIDTH, 3: RAM address width; depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits.
- AFULL_THRESH, 6: afull asserted when level >= value; range 1..2^ADDRWIDTH.
- AEMPTY_THRESH, 2: aempty asserted when level <= value; range 0..2^ADDRWIDTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write request.
- re  in  1  read request.
- ram_we  out  1  RAM write enable = we & ~full (combinational).
- ram_re  out  1  RAM read enable = re & ~empty (combinational).
- waddr  out  ADDRWIDTH  RAM write address = wptr_bin[ADDRWIDTH-1:0].
- raddr  out  ADDRWIDTH  RAM read address = rptr_bin[ADDRWIDTH-1:0].
- full, empty, afull, aempty  out  1 each  registered status flags.
- level  out  ADDRWIDTH+1  registered occupancy, 0..2^ADDRWIDTH.
- dvld  out  1  read data valid; asserted one cycle after ram_re.
- wptr_gray, rptr_gray  out  ADDRWIDTH+1  registered Gray pointers.
- overflow, underflow  out  1  error pulses; present only with FIFO_ERR_FLAGS_EN.

## Operation
- Reset values: all pointers 0; level 0; empty=1; aempty=1; full=0; afull=0 (AFULL_THRESH>=1); dvld=0; overflow=0; underflow=0; gray pointers 0.
- Accepted write (ram_we): wptr_bin increments modulo 2^(ADDRWIDTH+1). Accepted read (ram_re): rptr_bin increments the same way.
- Gray pointers: gray = bin ^ (bin>>1), registered alongside the binary pointer. Exactly one bit changes per increment, including at wrap.
- Level update: +1 on write only; -1 on read only; unchanged on both or neither.
- Flags are computed from the next-state level and registered: full = (level==2^ADDRWIDTH); empty = (level==0).
- Full: writes are blocked even when a read occurs in the same cycle. The read proceeds and full drops on the next cycle.
- Empty: reads are blocked even when a write occurs in the same cycle. The write proceeds and empty drops on the next cycle.
- Simultaneous accepted read and write: both pointers advance; level and flags are unchanged.
- Wrap-around: the pointer MSB toggles when the address field rolls from 2^ADDRWIDTH-1 to 0. Level is held as an explicit counter, not derived from pointer difference.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight dvld is cleared and no error pulse is generated in that cycle.

## Timing
- ram_we, ram_re, waddr and raddr are valid in the request cycle. The RAM samples them on the same edge that advances the pointers.
- Flags, level and gray pointers reflect an accepted operation one cycle later (edge N+1 after request cycle N).
- dvld is high for exactly one cycle at N+1 for each ram_re in cycle N. Back-to-back reads give a continuous dvld.

## Configuration
- FIFO_ERR_FLAGS_EN defined: the overflow and underflow ports exist.
  - overflow is a one-cycle registered pulse at N+1 when we & full in cycle N.
  - underflow is the same for re & empty.
- FIFO_ERR_FLAGS_EN undefined: both ports and their registers are absent; blocked requests are silently dropped.

## Structure
- Shared package holds:
  - the pointer-width function (ADDRWIDTH+1);
  - the depth constant (1<<ADDRWIDTH);
  - the bin-to-Gray function, reused by the future dual-clock variant.
- One sub-module, fifo_bin2gray: combinational converter, ADDRWIDTH parameter. It is instantiated twice, for the write and read pointers.

## Test plan
- Reset, then idle: empty=1, aempty=1, full=0, level=0, gray pointers 0, dvld=0.
- 8 writes (ADDRWIDTH=3), no reads: level counts 1..8; afull rises when level reaches 6; full=1 after the 8th write; a 9th write gives ram_we=0 and waddr stays 0. With the macro, overflow pulses once.
- From full, read and write together in one cycle: read accepted, write blocked; next cycle level=7, full=0.
- From empty, read and write together: write accepted, ram_re=0, dvld stays 0; next cycle level=1, empty=0. With the macro, underflow pulses once.
- 20 alternating write/read pairs: pointers wrap past 15 to 0; each gray pointer changes exactly one bit per step; dvld follows every accepted read by one cycle.
- Assert reset with level=5 mid-stream: next cycle all outputs hold reset values and dvld is 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared FIFO pointer helpers: pointer width, depth and binary-to-Gray conversion.
// Also used by the planned dual-clock variant.
package fifo_ptr_ctrl_pkg;

  localparam int unsigned FIFO_ADDRWIDTH_DEF = 32'd3;
  localparam int unsigned FIFO_DEPTH_DEF     = 32'd1 << FIFO_ADDRWIDTH_DEF;

  function automatic int unsigned fifo_ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Callers size-cast the result down to their pointer width.
  function automatic logic [31:0] fifo_bin2gray_f(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// User/RAM-side signal bundle of the FIFO pointer controller.
// FIFO_ERR_FLAGS_EN adds the overflow/underflow error pulses.
interface fifo_ptr_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  logic                 we;
  logic                 re;
  logic                 ram_we;
  logic                 ram_re;
  logic [ADDRWIDTH-1:0] waddr;
  logic [ADDRWIDTH-1:0] raddr;
  logic                 full;
  logic                 empty;
  logic                 afull;
  logic                 aempty;
  logic [ADDRWIDTH:0]   level;
  logic                 dvld;
  logic [ADDRWIDTH:0]   wptr_gray;
  logic [ADDRWIDTH:0]   rptr_gray;
`ifdef FIFO_ERR_FLAGS_EN
  logic                 overflow;
  logic                 underflow;
`endif

  modport master (
    output we, re,
    input  ram_we, ram_re, waddr, raddr, full, empty, afull, aempty,
    input  level, dvld, wptr_gray, rptr_gray
`ifdef FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  we, re,
    output ram_we, ram_re, waddr, raddr, full, empty, afull, aempty,
    output level, dvld, wptr_gray, rptr_gray
`ifdef FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/fifo_bin2gray.sv
// Combinational binary-to-Gray converter for an (ADDRWIDTH+1)-bit FIFO pointer.
module fifo_bin2gray
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH:0] bin,
  output logic [ADDRWIDTH:0] gray
);
  localparam int unsigned PW = ADDRWIDTH + 32'd1;

  assign gray = PW'(fifo_bin2gray_f(32'(bin)));

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller driving a synchronous dual-port RAM.
// Optional FIFO_ERR_FLAGS_EN adds registered overflow/underflow pulses.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 3,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic           clk,
  input  logic           reset,
  fifo_ptr_ctrl_if.slave bus
);
  localparam int unsigned   PW       = fifo_ptr_width(ADDRWIDTH);
  localparam logic [PW-1:0] DEPTH_L  = PW'(fifo_depth(ADDRWIDTH));
  localparam logic [PW-1:0] ONE_L    = PW'(1);
  localparam logic [PW-1:0] ZERO_L   = PW'(0);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wptr_r, rptr_r, level_r;
  logic [PW-1:0] wptr_nxt_s, rptr_nxt_s, level_nxt_s;
  logic [PW-1:0] wgray_r, rgray_r, wgray_nxt_s, rgray_nxt_s;
  logic          full_r, empty_r, afull_r, aempty_r, dvld_r;
  logic          wr_acc_s, rd_acc_s;

  // Blocking uses the registered flags, so a full FIFO refuses writes even with a concurrent read.
  assign wr_acc_s   = bus.we & ~full_r;
  assign rd_acc_s   = bus.re & ~empty_r;

  assign bus.ram_we    = wr_acc_s;
  assign bus.ram_re    = rd_acc_s;
  assign bus.waddr     = wptr_r[ADDRWIDTH-1:0];
  assign bus.raddr     = rptr_r[ADDRWIDTH-1:0];
  assign bus.full      = full_r;
  assign bus.empty     = empty_r;
  assign bus.afull     = afull_r;
  assign bus.aempty    = aempty_r;
  assign bus.level     = level_r;
  assign bus.dvld      = dvld_r;
  assign bus.wptr_gray = wgray_r;
  assign bus.rptr_gray = rgray_r;

  // Next-state pointers and explicit occupancy counter.
  always_comb begin
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    level_nxt_s = level_r;
    if (wr_acc_s) begin
      wptr_nxt_s = wptr_r + ONE_L;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_acc_s) begin
      rptr_nxt_s = rptr_r + ONE_L;
    end else begin
      rptr_nxt_s = rptr_r;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + ONE_L;
      2'b01:   level_nxt_s = level_r - ONE_L;
      default: level_nxt_s = level_r;
    endcase
  end

  fifo_bin2gray #(.ADDRWIDTH(ADDRWIDTH)) u_wgray (.bin(wptr_nxt_s), .gray(wgray_nxt_s));
  fifo_bin2gray #(.ADDRWIDTH(ADDRWIDTH)) u_rgray (.bin(rptr_nxt_s), .gray(rgray_nxt_s));

  // Pointer, Gray, level, flag and read-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r   <= ZERO_L;
      rptr_r   <= ZERO_L;
      wgray_r  <= ZERO_L;
      rgray_r  <= ZERO_L;
      level_r  <= ZERO_L;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      dvld_r   <= 1'b0;
    end else begin
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      wgray_r  <= wgray_nxt_s;
      rgray_r  <= rgray_nxt_s;
      level_r  <= level_nxt_s;
      full_r   <= (level_nxt_s == DEPTH_L);
      empty_r  <= (level_nxt_s == ZERO_L);
      afull_r  <= (level_nxt_s >= AFULL_L);
      aempty_r <= (level_nxt_s <= AEMPTY_L);
      dvld_r   <= rd_acc_s;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r, underflow_r;

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

  // One-cycle pulses for requests refused by the current flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= bus.we & full_r;
      underflow_r <= bus.re & empty_r;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (ADDRWIDTH=3, AFULL=6, AEMPTY=2).
module tb_fifo_ptr_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errs   = 0;
  int   checks = 0;
  int   wp, rp;
  logic [3:0] prev_wg, prev_rg;

  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.ADDRWIDTH(3)) bus ();

  fifo_ptr_ctrl #(
    .ADDRWIDTH(3),
    .AFULL_THRESH(6),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  // Apply requests after the falling edge; combinational outputs settle by #1.
  task automatic set_req(input logic w, input logic r);
    @(negedge clk);
    bus.we = w;
    bus.re = r;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_empty"}, bus.empty, 1);
    check_eq({pfx, "_aempty"}, bus.aempty, 1);
    check_eq({pfx, "_full"}, bus.full, 0);
    check_eq({pfx, "_afull"}, bus.afull, 0);
    check_eq({pfx, "_level"}, bus.level, 0);
    check_eq({pfx, "_wgray"}, bus.wptr_gray, 0);
    check_eq({pfx, "_rgray"}, bus.rptr_gray, 0);
    check_eq({pfx, "_dvld"}, bus.dvld, 0);
  endtask

  initial begin
    reset  = 1'b1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 0);
    clk_edge();
    check_reset_state("idle");
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("idle_ovf", bus.overflow, 0);
    check_eq("idle_unf", bus.underflow, 0);
`endif

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      set_req(1, 0);
      check_eq("fill_ram_we", bus.ram_we, 1);
      check_eq("fill_waddr", bus.waddr, i);
      clk_edge();
      check_eq("fill_level", bus.level, i + 1);
      check_eq("fill_afull", bus.afull, (i + 1 >= 6) ? 1 : 0);
      check_eq("fill_aempty", bus.aempty, (i + 1 <= 2) ? 1 : 0);
      check_eq("fill_full", bus.full, (i + 1 == 8) ? 1 : 0);
      check_eq("fill_empty", bus.empty, 0);
      check_eq("fill_wgray", bus.wptr_gray, gray4(i + 1));
      check_eq("fill_dvld", bus.dvld, 0);
    end
    wp = 8;
    rp = 0;

    set_req(1, 0);
    check_eq("ovr_ram_we", bus.ram_we, 0);
    check_eq("ovr_waddr", bus.waddr, 0);
    clk_edge();
    check_eq("ovr_level", bus.level, 8);
    check_eq("ovr_full", bus.full, 1);
    check_eq("ovr_wgray", bus.wptr_gray, gray4(8));
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("ovr_pulse", bus.overflow, 1);
`endif
    set_req(0, 0);
    clk_edge();
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("ovr_pulse_end", bus.overflow, 0);
`endif
    check_eq("ovr_hold_level", bus.level, 8);

    // Full: read accepted, write blocked
    set_req(1, 1);
    check_eq("fullrw_ram_we", bus.ram_we, 0);
    check_eq("fullrw_ram_re", bus.ram_re, 1);
    check_eq("fullrw_raddr", bus.raddr, 0);
    clk_edge();
    rp = 1;
    check_eq("fullrw_level", bus.level, 7);
    check_eq("fullrw_full", bus.full, 0);
    check_eq("fullrw_afull", bus.afull, 1);
    check_eq("fullrw_dvld", bus.dvld, 1);
    check_eq("fullrw_rgray", bus.rptr_gray, gray4(1));
    check_eq("fullrw_wgray", bus.wptr_gray, gray4(8));

    for (int i = 0; i < 7; i++) begin
      set_req(0, 1);
      check_eq("drain_raddr", bus.raddr, rp & 7);
      clk_edge();
      rp++;
      check_eq("drain_dvld", bus.dvld, 1);
      check_eq("drain_level", bus.level, 6 - i);
    end
    check_eq("drain_empty", bus.empty, 1);
    check_eq("drain_aempty", bus.aempty, 1);

    set_req(0, 0);
    clk_edge();
    check_eq("idle_dvld", bus.dvld, 0);

    // Empty: write accepted, read blocked
    set_req(1, 1);
    check_eq("emptyrw_ram_re", bus.ram_re, 0);
    check_eq("emptyrw_ram_we", bus.ram_we, 1);
    check_eq("emptyrw_waddr", bus.waddr, 0);
    clk_edge();
    wp = 9;
    check_eq("emptyrw_level", bus.level, 1);
    check_eq("emptyrw_empty", bus.empty, 0);
    check_eq("emptyrw_dvld", bus.dvld, 0);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("unf_pulse", bus.underflow, 1);
`endif
    set_req(0, 1);
    check_eq("emptyrw2_ram_re", bus.ram_re, 1);
    clk_edge();
    rp = 9;
    check_eq("emptyrw2_level", bus.level, 0);
    check_eq("emptyrw2_dvld", bus.dvld, 1);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("unf_pulse_end", bus.underflow, 0);
`endif

    // Alternating write/read pairs, pointers wrap past 15
    prev_wg = gray4(wp);
    prev_rg = gray4(rp);
    for (int k = 0; k < 20; k++) begin
      set_req(1, 0);
      check_eq("alt_waddr", bus.waddr, wp & 7);
      clk_edge();
      wp++;
      check_eq("alt_wgray", bus.wptr_gray, gray4(wp));
      check_eq("alt_wgray_1bit", $countones(prev_wg ^ bus.wptr_gray), 1);
      check_eq("alt_w_dvld", bus.dvld, 0);
      check_eq("alt_w_level", bus.level, 1);
      prev_wg = bus.wptr_gray;
      set_req(0, 1);
      check_eq("alt_ram_re", bus.ram_re, 1);
      check_eq("alt_raddr", bus.raddr, rp & 7);
      clk_edge();
      rp++;
      check_eq("alt_rgray", bus.rptr_gray, gray4(rp));
      check_eq("alt_rgray_1bit", $countones(prev_rg ^ bus.rptr_gray), 1);
      check_eq("alt_r_dvld", bus.dvld, 1);
      check_eq("alt_r_level", bus.level, 0);
      prev_rg = bus.rptr_gray;
    end

    // Reset with level=5 and a read in flight
    for (int i = 0; i < 5; i++) begin
      set_req(1, 0);
      clk_edge();
    end
    check_eq("pre_rst_level", bus.level, 5);
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b1;
    reset  = 1'b1;
    clk_edge();
    check_reset_state("midrst");
    check_eq("midrst_ram_re", bus.ram_re, 0);
    check_eq("midrst_raddr", bus.raddr, 0);
    check_eq("midrst_waddr", bus.waddr, 0);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("midrst_ovf", bus.overflow, 0);
    check_eq("midrst_unf", bus.underflow, 0);
`endif
    @(negedge clk);
    reset  = 1'b0;
    bus.re = 1'b0;
    clk_edge();
    check_eq("postrst_level", bus.level, 0);
    check_eq("postrst_empty", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
